// File: rtl/norm_shft_pkg.sv
// rtl/norm_shft_pkg.sv - shared func codes, FSM states and limits for the normalizer.
// FAST_NORM_EN selects the coarse 8-bit skip build.
package norm_shft_pkg;

  localparam logic [4:0] FUNC_SLL = 5'h0c;
  localparam logic [4:0] FUNC_SLR = 5'h0d;
  localparam logic [4:0] FUNC_SRA = 5'h0e;

  localparam logic [4:0] MAX_CNT  = 5'd31;
  localparam logic [4:0] SKIP_CNT = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

`ifdef FAST_NORM_EN
  localparam bit FAST_NORM = 1'b1;
`else
  localparam bit FAST_NORM = 1'b0;
`endif

endpackage

// File: rtl/norm_shft_detect.sv
// rtl/norm_shft_detect.sv - norm_detect: terminal, coarse-skip and saturate decode.
// The skip output is only live when FAST_NORM_EN is defined.
module norm_detect
  import norm_shft_pkg::*;
(
  input  logic [31:0] i_reg,
  input  logic [4:0]  i_func,
  input  logic [4:0]  i_cnt,
  output logic        o_term,
  output logic        o_skip,
  output logic        o_sat
);

  logic w_skip_raw;
  logic w_cnt_ok;

  assign w_cnt_ok = (i_cnt <= SKIP_CNT);
  assign o_sat    = (i_cnt == MAX_CNT);

  always_comb begin
    o_term     = 1'b1;
    w_skip_raw = 1'b0;
    case (i_func)
      FUNC_SLL: begin
        o_term     = i_reg[31];
        w_skip_raw = (i_reg[31:24] == 8'h00) && w_cnt_ok;
      end
      FUNC_SRA: begin
        // Nine equal top bits means eight of them are redundant sign copies.
        o_term     = i_reg[31] ^ i_reg[30];
        w_skip_raw = ((&i_reg[31:23]) || !(|i_reg[31:23])) && w_cnt_ok;
      end
      FUNC_SLR: o_term = 1'b1;
      default:  o_term = 1'b1;
    endcase
  end

  assign o_skip = FAST_NORM && w_skip_raw;

endmodule

// File: rtl/norm_shft.sv
// rtl/norm_shft.sv - sequential normalizer: left-shifts until the leading significant
// bit reaches bit 31 and reports the shift count with c/v/n/z flags.
module norm_shft
  import norm_shft_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       func,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] shft_amnt,
  output logic             c,
  output logic             v,
  output logic             n,
  output logic             z
);

  state_t           r_state;
  logic [WIDTH-1:0] r_reg;
  logic [4:0]       r_func;
  logic [CNT_W-1:0] r_cnt;
  logic             r_c;
  logic             r_armed;
  logic [WIDTH-1:0] r_dout;
  logic [CNT_W-1:0] r_amnt;
  logic             r_cout;
  logic             r_v;
  logic             r_n;
  logic             r_z;

  logic w_term;
  logic w_skip;
  logic w_sat;

  norm_detect u_detect (
    .i_reg  (r_reg),
    .i_func (r_func),
    .i_cnt  (r_cnt),
    .o_term (w_term),
    .o_skip (w_skip),
    .o_sat  (w_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_reg   <= '0;
      r_func  <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_armed <= 1'b0;
      r_dout  <= '0;
      r_amnt  <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_n     <= 1'b0;
      r_z     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_reg   <= din;
            r_func  <= func;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_armed <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_state <= IDLE;
          end
        end
        SHIFT: begin
          // The first SHIFT cycle only arms the detector on the captured operand.
          if (!r_armed) begin
            r_armed <= 1'b1;
          end else if (w_term || w_sat) begin
            r_state <= DONE;
            r_dout  <= r_reg;
            r_amnt  <= r_cnt;
            r_cout  <= r_c;
            r_v     <= w_sat && !w_term;
            r_n     <= r_reg[WIDTH-1];
            r_z     <= (r_reg == '0);
          end else if (w_skip) begin
            r_reg <= {r_reg[WIDTH-9:0], 8'h00};
            r_cnt <= r_cnt + CNT_W'(8);
            r_c   <= r_reg[WIDTH-8];
          end else begin
            r_reg <= {r_reg[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt + CNT_W'(1);
            r_c   <= r_reg[WIDTH-1];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = (r_state == SHIFT);
  assign done      = (r_state == DONE);
  assign dout      = r_dout;
  assign shft_amnt = r_amnt;
  assign c         = r_cout;
  assign v         = r_v;
  assign n         = r_n;
  assign z         = r_z;

endmodule
